hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline control unit for the 5-stage RV32I core. It watches the ID, EX and MEM stages and the instruction/data memory handshakes, and drives the stall/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers plus the PC enable. It also:
- discards a fetch that was in flight when a jump/branch redirected the PC;
- keeps stall/flush performance counters;
- flags a data-memory timeout.

## Interface
Parameters:
- CNT_W, 32, width of performance counters
- MEM_TIMEOUT, 255, max consecutive dmem wait cycles before timeout flag

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_jb  in  1  jump taken or branch condition true, resolved in EX
- imem_ready  in  1  instruction word on imem data is valid this cycle
- dmem_req  in  1  MEM-stage load/store active
- dmem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC register update enable
- if_id_stall, if_id_flush  out  1 each  IF/ID hold / replace with nop (0x00000013)
- id_ex_stall, id_ex_flush  out  1 each  ID/EX hold / insert bubble
- ex_mem_stall  out  1  EX/MEM hold
- mem_wb_flush  out  1  MEM/WB insert bubble
- stall_cnt  out  CNT_W  cycles with pc_en low outside reset
- flush_cnt  out  CNT_W  count of ex_jb redirects taken
- mem_timeout  out  1  sticky timeout flag

## Operation
Hazard terms (combinational):
- dwait = dmem_req & ~dmem_ready
- lu = ex_is_load & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
- iwait = ~imem_ready

Priority, highest first; exactly one applies:
- dwait:
  - pc_en=0
  - if_id_stall=id_ex_stall=ex_mem_stall=1
  - mem_wb_flush=1
  - ex_jb is ignored; it stays asserted because EX is frozen
- ex_jb:
  - pc_en=1
  - if_id_flush=id_ex_flush=1
  - flush_cnt+1
- lu:
  - pc_en=0
  - if_id_stall=1
  - id_ex_flush=1, giving a 1-cycle bubble
- iwait or state DROP:
  - pc_en=0
  - if_id_flush=1, so nops enter ID while the fetch is pending
- none: pc_en=1, all stall/flush outputs 0.

FSM, states RUN and DROP:
- RUN→DROP: ex_jb & ~dwait & iwait. The redirect occurs while a fetch of the old path is outstanding.
- DROP: the word arriving with imem_ready is discarded (if_id_flush=1, pc_en=0).
- DROP→RUN: on imem_ready. The next cycle fetches the redirect target normally.
- A new ex_jb while in DROP stays in DROP.

Counters:
- stall_cnt increments every cycle with pc_en=0.
- Both counters wrap modulo 2^CNT_W.

Timeout:
- A wait counter of width clog2(MEM_TIMEOUT+1) increments while dwait and clears otherwise.
- When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until rst.
- The wait counter saturates and does not wrap.

## Timing
- All stall/flush/pc_en outputs are combinational from the inputs and the FSM state, valid in the same cycle. Zero latency.
- stall_cnt/flush_cnt update at the posedge following the qualifying cycle.
- Reset values:
  - state=RUN
  - stall_cnt=0, flush_cnt=0, wait counter=0, mem_timeout=0
  - while rst=1: pc_en=0, all stall/flush outputs 0
- Reset mid-DROP returns to RUN immediately (async); the pending fetch is not discarded.
- Simultaneous lu and ex_jb: ex_jb wins. The ID instruction is flushed, so no bubble is needed.
- Simultaneous dwait and ex_jb: dwait wins. flush_cnt does not count until the cycle the flush is actually issued.
- lu with iwait: lu outputs apply; the IF/ID hold keeps the ID instruction.

## Structure
- Shared package pipe_pkg:
  - NOP_INST=32'h00000013
  - FSM state enum (RUN, DROP)
  - register-index width constant 5
- Sub-module hazard_detect: combinational lu comparison, reusable by the forwarding unit.
- The FSM, counters and priority mux live in hazard_ctrl.

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle with pc_en=0, if_id_stall=1, id_ex_flush=1; next cycle (ex_is_load=0) all 0; stall_cnt=1.
- ex_rd=0 load with id_rs1=0 → no stall.
- Branch: ex_jb=1 with imem_ready=1 → if_id_flush=id_ex_flush=1, pc_en=1, flush_cnt=1, state stays RUN.
- Redirect during fetch: ex_jb=1, imem_ready=0 → state DROP. imem_ready held low 3 cycles, then high → that cycle if_id_flush=1, pc_en=0. Next cycle RUN with pc_en=1.
- Data wait: dmem_req=1, dmem_ready=0 for 4 cycles with ex_jb=1 → ex_mem_stall=1 and mem_wb_flush=1 each cycle, flush_cnt unchanged. On dmem_ready=1 the flush is issued and flush_cnt+1.
- Timeout and reset: MEM_TIMEOUT=8, dwait for 10 cycles → mem_timeout=1 after the 8th cycle and stays 1 after dwait ends. Async rst mid-DROP → mem_timeout=0, counters 0, state RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared types and constants for the 5-stage RV32I pipeline
//            control logic (hazard control, forwarding).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Architectural register index width (x0..x31)
  localparam int REG_IDX_W = 5;

  // Canonical nop (addi x0, x0, 0) injected into IF/ID on a flush
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Fetch-discard FSM: RUN is normal fetch, DROP discards one stale fetch
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DROP = 1'b1
  } state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use hazard detection. Flags when the ID
//            instruction reads a register that a load in EX is about to
//            write. x0 is never a hazard since it is hardwired to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 ex_is_load_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  output logic                 load_use_o
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Source-operand match against the EX destination, only for operands used
  always_comb begin
    w_rd_nonzero = (ex_rd_i != '0);
    w_rs1_hit    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
    w_rs2_hit    = id_use_rs2_i & (id_rs2_i == ex_rd_i);
    load_use_o   = ex_is_load_i & w_rd_nonzero & (w_rs1_hit | w_rs2_hit);
  end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline control for the 5-stage RV32I core. Resolves data-memory
//            waits, taken jumps/branches, load-use hazards and fetch waits into
//            stall/flush controls and the PC enable. Discards a stale fetch
//            that was in flight when the PC was redirected, counts stall and
//            redirect events, and flags an over-long data-memory wait.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_jb,
  input  logic                 imem_ready,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 mem_wb_flush,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic                 mem_timeout
);

  // Wait counter must hold MEM_TIMEOUT itself; keep at least one bit
  localparam int                WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;

  logic               w_dwait;
  logic               w_iwait;
  logic               w_lu;
  logic               w_drop;
  logic               w_flush_issue;
  logic               w_redirect_pending;

  hazard_detect u_hazard_detect (
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .load_use_o   (w_lu)
  );

  // Raw hazard terms from the memory handshakes and FSM state
  always_comb begin
    w_dwait            = dmem_req & ~dmem_ready;
    w_iwait            = ~imem_ready;
    w_drop             = (state_q == DROP);
    // Redirect issued while the old-path fetch has not yet returned
    w_redirect_pending = ex_jb & ~w_dwait & w_iwait;
  end

  // Priority mux: dmem wait > redirect > load-use > fetch wait/discard > run
  always_comb begin
    pc_en         = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_flush  = 1'b0;
    w_flush_issue = 1'b0;
    if (!rst) begin
      if (w_dwait) begin
        // Freeze IF..EX; EX stays frozen so a pending ex_jb is retried later
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_jb) begin
        // Flushing ID also covers a simultaneous load-use, so no bubble needed
        pc_en         = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        w_flush_issue = 1'b1;
      end else if (w_lu) begin
        // Hold ID one cycle and feed a bubble into EX
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_iwait || w_drop) begin
        // Nops enter ID while the fetch is pending or being discarded
        if_id_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  // Fetch-discard FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (w_redirect_pending) state_d = DROP;
      end
      DROP: begin
        if (w_redirect_pending)  state_d = DROP;
        else if (imem_ready)     state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Performance counters and the saturating dmem wait counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_d      = '0;
    if (!pc_en)        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (w_flush_issue) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (w_dwait) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end
    // Set as the wait count reaches the limit so the flag is visible right after
    timeout_d = timeout_q | (w_dwait & (wait_d == WAIT_MAX));
  end

  // State and counter registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = timeout_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Directed vectors push their
//            expected outputs into a queue; a monitor pops and compares on
//            every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  // Control vector order: {pc_en, if_id_stall, if_id_flush, id_ex_stall,
  //                        id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] C_RST  = 7'b0000000;
  localparam logic [6:0] C_IDLE = 7'b1000000;
  localparam logic [6:0] C_LU   = 7'b0100100;
  localparam logic [6:0] C_JB   = 7'b1010100;
  localparam logic [6:0] C_IW   = 7'b0010000;
  localparam logic [6:0] C_DW   = 7'b0101011;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_jb;
  logic        imem_ready, dmem_req, dmem_ready;
  logic        pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_flush, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [6:0]  ctrl;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_jb        (ex_jb),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_flush (mem_wb_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .mem_timeout  (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, expv);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle
  initial begin : monitor
    exp_t e;
    int   step;
    step = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        step++;
        chk("ctrl", step, {25'd0, pc_en, if_id_stall, if_id_flush, id_ex_stall,
                           id_ex_flush, ex_mem_stall, mem_wb_flush}, {25'd0, e.ctrl});
        chk("stall_cnt", step, stall_cnt, e.sc);
        chk("flush_cnt", step, flush_cnt, e.fc);
        chk("mem_timeout", step, {31'd0, mem_timeout}, {31'd0, e.to});
      end
    end
  end

  // One cycle of stimulus plus its expected outputs
  task automatic cyc(input logic r, input logic jb, input logic ir, input logic dq, input logic dr,
                     input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic [6:0] ec, input int sc, input int fc, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_jb = jb; imem_ready = ir; dmem_req = dq; dmem_ready = dr;
    ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    e.ctrl = ec; e.sc = sc; e.fc = fc; e.to = to;
    exp_q.push_back(e);
  endtask

  initial begin : stim
    rst = 1'b1; ex_jb = 1'b0; imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    ex_is_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_use_rs1 = 1'b0; id_rs2 = '0; id_use_rs2 = 1'b0;

    //   r  jb ir dq dr ld rd     r1     u1 r2     u2  ctrl    sc  fc  to
    cyc(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RST,  0,  0, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 0,  0, 0);
    // load-use on rs1, then clear
    cyc(0, 0, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_LU,   0,  0, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 1,  0, 0);
    // load to x0 is never a hazard
    cyc(0, 0, 1, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, C_IDLE, 1,  0, 0);
    // load-use on rs2
    cyc(0, 0, 1, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, C_LU,   1,  0, 0);
    // matching but unused operands, and non-load match
    cyc(0, 0, 1, 0, 0, 1, 5'd7, 5'd7, 0, 5'd7, 0, C_IDLE, 2,  0, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd7, 5'd7, 1, 5'd0, 0, C_IDLE, 2,  0, 0);
    // branch with fetch ready: stays RUN
    cyc(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_JB,   2,  0, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 2,  1, 0);
    // load-use together with branch: branch wins
    cyc(0, 1, 1, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_JB,   2,  1, 0);
    // load-use with fetch wait: load-use wins
    cyc(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_LU,   2,  2, 0);
    // plain fetch wait
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IW,   3,  2, 0);
    // redirect during outstanding fetch -> DROP for 3 waits + arriving word
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_JB,   4,  2, 0);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IW,   4,  3, 0);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IW,   5,  3, 0);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IW,   6,  3, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IW,   7,  3, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 8,  3, 0);
    // data wait masks a pending branch for 4 cycles, then flush issues
    cyc(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_DW,   8,  3, 0);
    cyc(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_DW,   9,  3, 0);
    cyc(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_DW,  10,  3, 0);
    cyc(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_DW,  11,  3, 0);
    cyc(0, 1, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_JB,  12,  3, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,12,  4, 0);
    // 10 dwait cycles: timeout visible from the 9th cycle on
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_DW, 11 + i, 4, (i >= 9) ? 1'b1 : 1'b0);
    end
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,22,  4, 1);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,22,  4, 1);
    // enter DROP, then asynchronous reset mid-cycle
    cyc(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_JB,  22,  4, 1);
    cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IW,  22,  5, 1);
    cyc(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RST,  0,  0, 0);
    // back in RUN: ready fetch gives normal operation, no discard
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 0,  0, 0);
    cyc(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 0,  0, 0);

    // Let the monitor drain the queue, with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
